// File: rtl/tx_arbiter_if.sv
// Requester and transmitter handshake bundle for tx_arbiter.
// master is the arbiter side, slave is the requester/transmitter side.
interface tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt1;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;

  modport master (
    input  req0, data0, req1, data1, tx_ready,
    output gnt0, gnt1, tx_data, tx_start
  );

  modport slave (
    output req0, data0, req1, data1, tx_ready,
    input  gnt0, gnt1, tx_data, tx_start
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between two
// byte sources; latches the winner's byte and tracks tx_ready.
module tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  tx_arbiter_if.master     bus,
  output logic             busy,
  output logic             owner,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_nxt;
  logic          rr_ptr;
  logic          grant;
  logic          win;

  always_comb begin
    grant  = en & bus.tx_ready & (bus.req0 | bus.req1);
    win    = (bus.req0 & bus.req1) ? rr_ptr : bus.req1;
    to_nxt = to_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      rr_ptr       <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
      err_timeout  <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            bus.tx_data  <= win ? bus.data1 : bus.data0;
            bus.tx_start <= 1'b1;
            bus.gnt0     <= ~win;
            bus.gnt1     <= win;
            owner        <= win;
            rr_ptr       <= ~win;
            to_cnt       <= '0;
            state        <= WAIT_BUSY;
            busy         <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!bus.tx_ready) begin
            state <= WAIT_DONE;
          end else if (to_nxt == TW'(BUSY_TIMEOUT)) begin
            // Launch never taken: give up without counting or retrying.
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            to_cnt <= to_nxt;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
